// File: rtl/fifo_rr_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_drain_arbiter
// Description : Round-robin drain of N registered-read FIFOs onto one
//               valid/ready stream, tagging each word with its source index.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_drain_arbiter #(
    parameter  int N         = 4,
    parameter  int W         = 8,
    parameter  int MAX_BURST = 4,
    localparam int c_src_w   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         src_empty,
    input  logic [N*W-1:0]       src_data,
    output logic [N-1:0]         src_re,
    output logic [W-1:0]         out_data,
    output logic [c_src_w-1:0]   out_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_fetch = 2'd1;
    localparam logic [1:0] c_latch = 2'd2;
    localparam logic [1:0] c_out   = 2'd3;

    localparam int                 c_bw        = $clog2(MAX_BURST + 1);
    localparam logic [c_bw-1:0]    c_max_burst = c_bw'(MAX_BURST);
    localparam logic [c_src_w-1:0] c_last_init = c_src_w'(N - 1);

    logic [1:0]         r_state;
    logic [c_src_w-1:0] r_grant;
    logic [c_src_w-1:0] r_last;
    logic [c_bw-1:0]    r_burst_cnt;

    logic [W-1:0]       w_word [N];
    logic               w_found;
    logic [c_src_w-1:0] w_pick;
    logic [c_bw-1:0]    w_burst_next;
    logic               w_more;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_word[gi] = src_data[gi*W +: W];
        end
    endgenerate

    // Pointer arithmetic wraps by compare so non-power-of-2 N stays in range.
    function automatic logic [c_src_w-1:0] f_wrap(input int s);
        return (s >= N) ? c_src_w'(s - N) : c_src_w'(s);
    endfunction

    // Walk from farthest to nearest so the nearest non-empty source wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = N; k >= 1; k--) begin
            if (!src_empty[f_wrap(int'(r_last) + k)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap(int'(r_last) + k);
            end
        end
    end

    assign w_burst_next = r_burst_cnt + c_bw'(1);
    assign w_more       = (w_burst_next < c_max_burst) && en && !src_empty[r_grant];
    assign busy         = (r_state != c_idle);

    always_comb begin
        src_re = '0;
        if ((r_state == c_fetch) && !src_empty[r_grant]) begin
            src_re[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_grant     <= '0;
            r_last      <= c_last_init;
            r_burst_cnt <= '0;
            out_data    <= '0;
            out_src     <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (en && w_found) begin
                        r_grant     <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= c_fetch;
                    end
                end
                c_fetch: begin
                    // An empty source here means no read was issued; give up the grant.
                    r_state <= src_empty[r_grant] ? c_idle : c_latch;
                end
                c_latch: begin
                    out_data  <= w_word[r_grant];
                    out_src   <= r_grant;
                    out_valid <= 1'b1;
                    r_state   <= c_out;
                end
                c_out: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        r_burst_cnt <= w_burst_next;
                        if (w_more) begin
                            r_state <= c_fetch;
                        end else begin
                            r_last  <= r_grant;
                            r_state <= c_idle;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rr_drain_arbiter
// Description : Self-checking bench for fifo_rr_drain_arbiter with
//               registered-read FIFO models and a round-robin reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_drain_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           en        = 1'b0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   src_empty = '1;
    logic [N*W-1:0] src_data;
    logic [W-1:0]   dout [N] = '{default: '0};
    logic [N-1:0]   src_re;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           busy;

    always #5 clk = ~clk;

    fifo_rr_drain_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .src_empty (src_empty),
        .src_data  (src_data),
        .src_re    (src_re),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign src_data[gi*W +: W] = dout[gi];
        end
    endgenerate

    // Registered-read FIFO models; writes land one edge after being queued.
    logic [W-1:0] fq   [N][$];
    logic [W-1:0] pend [N][$];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (src_re[i] && fq[i].size() > 0) dout[i] <= fq[i].pop_front();
            while (pend[i].size() > 0) fq[i].push_back(pend[i].pop_front());
            src_empty[i] <= (fq[i].size() == 0);
        end
    end

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } word_t;

    word_t cap[$];
    int    stab_err = 0;
    int    re_err   = 0;
    logic  pv       = 1'b0;
    logic  pr       = 1'b1;
    word_t pw       = '0;

    always @(negedge clk) begin
        #2;
        if ($countones(src_re) > 1) re_err++;
        if (!rst && pv && !pr && (!out_valid || out_src != pw.src || out_data != pw.data)) stab_err++;
        pv = out_valid && !rst;
        pr = out_ready;
        pw = {out_src, out_data};
        if (out_valid && out_ready && !rst) cap.push_back({out_src, out_data});
    end

    int vec_cnt = 0;
    int miss    = 0;

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input int s, input logic [W-1:0] d);
        pend[s].push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        check("src_re_in_reset", int'(src_re), 0);
        rst = 1'b0;
        cap.delete();
    endtask

    task automatic wait_cap(input int n, input int budget, input bit rnd, input string name);
        int c;
        c = 0;
        while (cap.size() < n && c < budget) begin
            @(negedge clk);
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            c++;
        end
        if (cap.size() < n) check(name, cap.size(), n);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int c;
        c = 0;
        while (!out_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(out_valid), 1);
    endtask

    task automatic drain(input string name);
        int  c;
        bit  done;
        en        = 1'b1;
        out_ready = 1'b1;
        c         = 0;
        done      = 1'b0;
        while (!done && c < 600) begin
            @(negedge clk);
            c++;
            done = !busy && (src_empty == '1);
            for (int i = 0; i < N; i++) if (pend[i].size() > 0 || fq[i].size() > 0) done = 1'b0;
        end
        check(name, int'(done), 1);
    endtask

    typedef struct {
        int cnt[N];
        int len;
        int seq[24];
    } vec_t;

    vec_t vecs[3];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        word_t    exp_q[$];
        logic [W-1:0] mq[N][$];
        int       last, g, take, n, ncap;
        int       taken[N];
        bit       found;
        logic [W-1:0] d;

        vecs[0].cnt = '{6, 6, 6, 6};
        vecs[0].len = 24;
        vecs[0].seq = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
        vecs[1].cnt = '{0, 2, 0, 5};
        vecs[1].len = 7;
        vecs[1].seq = '{1,1,3,3,3,3,3, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[2].cnt = '{0, 5, 0, 0};
        vecs[2].len = 5;
        vecs[2].seq = '{1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

        // Reset state
        do_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data), 0);
        check("rst_out_src",   int'(out_src), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_src_re",    int'(src_re), 0);

        // Single word latency: IDLE at T, src_re at T+1, out_valid at T+3
        en        = 1'b1;
        out_ready = 1'b1;
        push(2, 8'hA5);
        @(negedge clk);
        check("lat_T_src_re", int'(src_re), 0);
        @(negedge clk);
        check("lat_T1_src_re", int'(src_re), 4'b0100);
        @(negedge clk);
        check("lat_T2_valid", int'(out_valid), 0);
        check("lat_T2_src_re", int'(src_re), 0);
        @(negedge clk);
        check("lat_T3_valid", int'(out_valid), 1);
        check("lat_T3_data", int'(out_data), 8'hA5);
        check("lat_T3_src", int'(out_src), 2);
        check("lat_T3_busy", int'(busy), 1);
        @(negedge clk);
        check("lat_T4_busy", int'(busy), 0);
        check("lat_T4_valid", int'(out_valid), 0);
        check("lat_count", cap.size(), 1);

        // Table-driven source patterns
        for (int v = 0; v < 3; v++) begin
            do_reset();
            out_ready = 1'b1;
            for (int s = 0; s < N; s++) begin
                taken[s] = 0;
                for (int k = 0; k < vecs[v].cnt[s]; k++) push(s, W'((s << 6) | k));
            end
            repeat (2) @(negedge clk);
            en = 1'b1;
            wait_cap(vecs[v].len, 400, 1'b0, "tbl_timeout");
            repeat (4) @(negedge clk);
            check("tbl_count", cap.size(), vecs[v].len);
            for (int j = 0; j < vecs[v].len; j++) begin
                if (j < cap.size()) begin
                    g = vecs[v].seq[j];
                    check("tbl_src", int'(cap[j].src), g);
                    check("tbl_data", int'(cap[j].data), (g << 6) | taken[g]);
                    taken[g]++;
                end
            end
            check("tbl_idle", int'(busy), 0);
        end

        // Back-pressure: word held stable, no reads while stalled
        do_reset();
        out_ready = 1'b0;
        en        = 1'b1;
        push(3, 8'h3C);
        wait_valid(20, "stall_valid_timeout");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_hold", int'({out_valid, out_src, out_data, src_re}),
                  int'({1'b1, 2'd3, 8'h3C, 4'b0000}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", int'(out_valid), 0);
        repeat (3) @(negedge clk);
        check("stall_handshakes", cap.size(), 1);

        // en dropped while word 2 of a source-0 burst is presented
        do_reset();
        for (int k = 0; k < 4; k++) push(0, W'(8'h10 + k));
        push(1, 8'h20);
        push(1, 8'h21);
        repeat (2) @(negedge clk);
        en        = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && cap.size() == 1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("endrop_count", cap.size(), 2);
        check("endrop_busy", int'(busy), 0);
        check("endrop_src_re", int'(src_re), 0);
        if (cap.size() >= 2) check("endrop_word2", int'(cap[1].data), 8'h11);
        en = 1'b1;
        wait_cap(3, 50, 1'b0, "endrop_resume_timeout");
        if (cap.size() >= 3) begin
            check("endrop_resume_src", int'(cap[2].src), 1);
            check("endrop_resume_data", int'(cap[2].data), 8'h20);
        end
        drain("endrop_drain");

        // Reset during LATCH restores source 0 priority
        do_reset();
        en        = 1'b1;
        out_ready = 1'b1;
        push(0, 8'h50);
        wait_cap(1, 30, 1'b0, "rstl_first_timeout");
        repeat (2) @(negedge clk);
        en = 1'b0;
        push(0, 8'h51);
        push(0, 8'h52);
        push(1, 8'h61);
        push(1, 8'h62);
        repeat (2) @(negedge clk);
        en = 1'b1;
        n  = 0;
        while (src_re == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstl_grant_after_0", int'(src_re), 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstl_valid", int'(out_valid), 0);
        check("rstl_busy", int'(busy), 0);
        rst = 1'b0;
        wait_cap(2, 50, 1'b0, "rstl_next_timeout");
        if (cap.size() >= 2) begin
            check("rstl_next_src", int'(cap[1].src), 0);
            check("rstl_next_data", int'(cap[1].data), 8'h51);
        end
        drain("rstl_drain");

        // Randomized contents and back-pressure against the round-robin model
        for (int it = 0; it < 12; it++) begin
            do_reset();
            out_ready = 1'b0;
            exp_q.delete();
            for (int s = 0; s < N; s++) begin
                mq[s].delete();
                n = $urandom_range(0, 7);
                for (int k = 0; k < n; k++) begin
                    d = W'($urandom);
                    push(s, d);
                    mq[s].push_back(d);
                end
            end
            last = N - 1;
            forever begin
                found = 1'b0;
                g     = 0;
                for (int k = 1; k <= N && !found; k++) begin
                    if (mq[(last + k) % N].size() > 0) begin
                        g     = (last + k) % N;
                        found = 1'b1;
                    end
                end
                if (!found) break;
                take = (mq[g].size() < MB) ? mq[g].size() : MB;
                for (int k = 0; k < take; k++) exp_q.push_back({2'(g), mq[g].pop_front()});
                last = g;
            end
            repeat (2) @(negedge clk);
            en = 1'b1;
            wait_cap(exp_q.size(), 800, 1'b1, "rand_timeout");
            out_ready = 1'b1;
            repeat (4) @(negedge clk);
            ncap = cap.size();
            check("rand_count", ncap, exp_q.size());
            for (int j = 0; j < exp_q.size(); j++) begin
                if (j < ncap) begin
                    check("rand_src", int'(cap[j].src), int'(exp_q[j].src));
                    check("rand_data", int'(cap[j].data), int'(exp_q[j].data));
                end
            end
            check("rand_idle", int'(busy), 0);
        end

        check("stall_stability", stab_err, 0);
        check("src_re_onehot", re_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Round-robin scheduler that drains N source FIFOs (our registered-read FIFO: `data_out` updates on the edge where `re & ~empty`) onto one valid/ready output stream.
- Sequences each source's `re`, absorbs the one-cycle read latency, and tags every output word with its source index.
- Sits between the per-sensor/per-UART FIFOs and the shared downstream consumer (packet formatter or TX path).

Parameters:
- N, 4, number of source FIFOs (N >= 2).
- W, 8, data word width; must match the source FIFO W.
- MAX_BURST, 4, maximum consecutive words taken from one source before the grant rotates (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  when low, no new grant is issued; an in-flight word still completes.
- src_empty  in  N  empty flags of the source FIFOs; bit i belongs to source i.
- src_data  in  N*W  source FIFO `data_out` buses; source i occupies bits [i*W +: W].
- src_re  out  N  one-hot read strobes to the source FIFOs.
- out_data  out  W  registered output word.
- out_src  out  max(1,$clog2(N))  index of the source that produced out_data.
- out_valid  out  1  out_data/out_src valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State IDLE; out_valid=0, out_data=0, out_src=0, burst_cnt=0, busy=0.
  - Round-robin pointer last=N-1, so source 0 has first priority.
  - src_re=0 during and after reset.
- States: IDLE, FETCH, LATCH, OUT.
- IDLE:
  - If en=1 and any src_empty bit is 0, select grant g = the first non-empty index searching last+1, last+2, ... modulo N.
  - Register g, clear burst_cnt, go to FETCH. Otherwise stay in IDLE.
- FETCH (exactly one cycle):
  - src_re = one-hot(g), asserted combinationally from state and g, and only if src_empty[g]=0.
  - If src_empty[g]=1 (defensive case), src_re=0 and the state returns to IDLE with last unchanged.
  - Otherwise go to LATCH.
- LATCH (one cycle): the FIFO `data_out` is now valid. Register out_data = src_data[g], out_src = g, set out_valid=1, go to OUT.
- OUT:
  - Hold out_valid, out_data and out_src stable until out_ready=1.
  - On handshake, burst_cnt increments.
  - If burst_cnt+1 < MAX_BURST, en=1 and src_empty[g]=0: clear out_valid and go to FETCH with the same g.
  - Otherwise: clear out_valid, set last=g, go to IDLE.
- Latency and throughput:
  - A word is visible at the source in cycle T (IDLE) -> src_re in T+1 -> out_valid in T+3.
  - Within a burst with out_ready held high: one word per 3 cycles (FETCH, LATCH, OUT).
  - Rotation to a new source costs one extra IDLE cycle.
- src_re is never asserted in IDLE, LATCH, OUT or during reset, and at most one bit is ever set.
- Fairness:
  - With all sources continuously non-empty and out_ready=1, grants cycle 0,1,...,N-1,0 with exactly MAX_BURST words each.
  - A source that goes empty mid-burst ends its burst early, and the grant rotates past it.
- en deasserted mid-burst: the current word completes through OUT, then the block returns to IDLE and stays there.
- Reset mid-operation:
  - The block returns to IDLE immediately.
  - A word already read from a FIFO (FETCH done) is discarded; this is accepted, since FIFOs and arbiter share rst in the system.
- Widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - The pointer increment wraps modulo N, with an explicit compare for non-power-of-2 N.

Test Plan:
- Reset, then source 2 alone holds 0xA5 -> src_re=4'b0100 in cycle T+1, out_valid=1 with out_data=0xA5 and out_src=2 in T+3, busy drops the cycle after the handshake.
- All 4 sources hold 6 words each, out_ready=1 -> output src sequence 0×4, 1×4, 2×4, 3×4, 0×2, 1×2, 2×2, 3×2; data order is preserved per source; no word is lost or duplicated.
- Source 1 has 2 words and source 3 has 5 words, MAX_BURST=4 -> src sequence 1,1,3,3,3,3,3; the burst from source 1 ends early on empty.
- out_ready held low for 10 cycles in OUT -> out_data and out_src are stable and src_re stays 0 throughout; after release, exactly one handshake occurs.
- en dropped during a source-0 burst at word 2 -> exactly 2 words are output, then the block sits in IDLE with busy=0; re-raising en resumes at source 1.
- rst asserted in LATCH -> the next cycle has out_valid=0 and state IDLE; source 0 wins the next arbitration.
